zap_ram_simple_be: RTL and testbench

- Parametrised 1R+1W block RAM, successor to the basic simple-dual-port RAM. Adds the following:
  - byte-enable writes;
  - write-first forwarding on same-cycle read/write collisions;
  - selectable read latency (1 or 2) with a read-valid flag;
  - post-reset hardware clear sweep, since an asynchronous reset cannot clear the array.
- Used for register files, cache tag/data arrays and TLB storage across the core.

---
 rtl/zap_ram_pkg.sv | 32 +++
 rtl/zap_ram_be_core.sv | 36 +++
 rtl/zap_ram_simple_be.sv | 172 +++++++++++++++++
 tb/tb_zap_ram_simple_be.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/zap_ram_pkg.sv
// Shared types and helpers for the zap byte-enable RAM: FSM encoding,
// read-latency legality check and the byte-merge used by write and forwarding.
package zap_ram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 512;

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] ben
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MERGE_W/8; k++) begin
            if (ben[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/zap_ram_be_core.sv
// Plain storage array with per-byte write enable and a registered read port.
// Read returns the pre-write contents on a same-address collision.
module zap_ram_be_core #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [WIDTH/8-1:0] i_wr_ben,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [WIDTH-1:0]   o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < WIDTH/8; k++) begin
                if (i_wr_ben[k]) begin
                    mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
                end
            end
        end
        if (i_rd_en) begin
            rd_q <= mem[i_rd_addr];
        end
    end

    assign o_rd_data = rd_q;

endmodule

// File: rtl/zap_ram_simple_be.sv
// 1R+1W byte-enable RAM with post-reset clear sweep, write-first forwarding
// and selectable read latency.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | sweeping INIT_VALUE into cnt 0..DEPTH-1 (or one idle cycle
//            | when INIT_SWEEP=0); user traffic dropped
//   ST_READY | sweep done, reads and writes accepted until next reset
module zap_ram_simple_be
    import zap_ram_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 32,
    parameter int               RD_LAT     = 1,
    parameter int               INIT_SWEEP = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH/8-1:0]         i_wr_ben,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_init_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("zap_ram_simple_be: RD_LAT must be 1 or 2");
    end
    if ((WIDTH % 8) != 0 || WIDTH > MERGE_W) begin : g_bad_width
        $error("zap_ram_simple_be: WIDTH must be a multiple of 8 and <= MERGE_W");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("zap_ram_simple_be: DEPTH must be >= 2");
    end

    ram_state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (INIT_SWEEP == 0) begin
                state_d = ST_READY;
            end else if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    logic ready;
    logic sweep_we;
    logic wr_in_range, rd_in_range;
    logic user_we, rd_acc;

    assign ready       = (state_q == ST_READY);
    assign sweep_we    = (state_q == ST_INIT) && (INIT_SWEEP != 0);
    assign wr_in_range = {1'b0, i_wr_addr} < (AW+1)'(DEPTH);
    assign rd_in_range = {1'b0, i_rd_addr} < (AW+1)'(DEPTH);
    assign user_we     = ready && i_wr_en && wr_in_range;
    assign rd_acc      = ready && i_rd_en;

    logic             core_we;
    logic [NB-1:0]    core_ben;
    logic [WIDTH-1:0] core_wdata;
    logic [AW-1:0]    core_waddr;
    logic [WIDTH-1:0] core_q;

    assign core_we    = sweep_we || user_we;
    assign core_ben   = sweep_we ? '1 : i_wr_ben;
    assign core_wdata = sweep_we ? INIT_VALUE : i_wr_data;
    assign core_waddr = sweep_we ? cnt_q : i_wr_addr;

    zap_ram_be_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .i_clk     (i_clk),
        .i_wr_en   (core_we),
        .i_wr_ben  (core_ben),
        .i_wr_addr (core_waddr),
        .i_wr_data (core_wdata),
        .i_rd_en   (rd_acc && rd_in_range),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (core_q)
    );

    // Same-cycle write is captured with the read so the merge after the core
    // sees exactly the bytes written at the issue edge and nothing later.
    logic             v1_q, oor1_q;
    logic [NB-1:0]    fwd_ben_q;
    logic [WIDTH-1:0] fwd_data_q;
    logic [NB-1:0]    fwd_ben;

    assign fwd_ben = (user_we && (i_wr_addr == i_rd_addr)) ? i_wr_ben : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            v1_q       <= 1'b0;
            oor1_q     <= 1'b0;
            fwd_ben_q  <= '0;
            fwd_data_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                oor1_q     <= !rd_in_range;
                fwd_ben_q  <= fwd_ben;
                fwd_data_q <= i_wr_data;
            end
        end
    end

    logic [WIDTH-1:0] merged1;

    assign merged1 = oor1_q ? '0
                   : WIDTH'(byte_merge(MERGE_W'(core_q), MERGE_W'(fwd_data_q),
                                       (MERGE_W/8)'(fwd_ben_q)));

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_q <= '0;
        end else if (v1_q) begin
            data_q <= merged1;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic v2_q;

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
            end
        end

        assign o_rd_data  = data_q;
        assign o_rd_valid = v2_q;
    end else begin : g_lat1
        // data_q only holds the last result between reads
        assign o_rd_data  = v1_q ? merged1 : data_q;
        assign o_rd_valid = v1_q;
    end

    assign o_init_done = ready;

endmodule

// File: tb/tb_zap_ram_simple_be.sv
// Randomised and directed bench for zap_ram_simple_be: three instances
// (DEPTH 32/RD_LAT 2, DEPTH 32/RD_LAT 1, DEPTH 24/RD_LAT 1) against a word-array model.
module tb_zap_ram_simple_be;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [3:0]  wr_ben;
    logic [31:0] wr_data;
    logic [4:0]  wr_addr, rd_addr;

    logic [31:0] rd_data   [3];
    logic        rd_valid  [3];
    logic        init_done [3];

    always #5 i_clk = ~i_clk;

    zap_ram_simple_be #(.WIDTH(32), .DEPTH(32), .RD_LAT(2), .INIT_SWEEP(1), .INIT_VALUE(IV)) u_a (
        .i_clk(i_clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_ben(wr_ben),
        .i_wr_data(wr_data), .i_wr_addr(wr_addr), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_init_done(init_done[0]));

    zap_ram_simple_be #(.WIDTH(32), .DEPTH(32), .RD_LAT(1), .INIT_SWEEP(1), .INIT_VALUE(IV)) u_b (
        .i_clk(i_clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_ben(wr_ben),
        .i_wr_data(wr_data), .i_wr_addr(wr_addr), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_init_done(init_done[1]));

    zap_ram_simple_be #(.WIDTH(32), .DEPTH(24), .RD_LAT(1), .INIT_SWEEP(1), .INIT_VALUE(IV)) u_c (
        .i_clk(i_clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_ben(wr_ben),
        .i_wr_data(wr_data), .i_wr_addr(wr_addr), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data[2]), .o_rd_valid(rd_valid[2]), .o_init_done(init_done[2]));

    // reference model: word array per instance, edges since reset, result pipe
    int          m_depth [3] = '{32, 32, 24};
    int          m_lat   [3] = '{2, 1, 1};
    logic [31:0] m_mem   [3][32];
    int          m_edges [3];
    bit          m_v     [3][2];
    logic [31:0] m_d     [3][2];
    logic [31:0] m_last  [3];

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_edges[i] = 0;
        m_v[i][0]  = 1'b0;
        m_v[i][1]  = 1'b0;
        m_d[i][0]  = '0;
        m_d[i][1]  = '0;
        m_last[i]  = '0;
    endtask

    task automatic model_edge(input int i);
        logic [31:0] rd, w;
        bit          rv;
        rv = 1'b0;
        rd = '0;
        if (m_edges[i] >= m_depth[i]) begin
            if (rd_en) begin
                rv = 1'b1;
                if (int'(rd_addr) < m_depth[i]) begin
                    rd = m_mem[i][rd_addr];
                    if (wr_en && wr_addr == rd_addr)
                        for (int k = 0; k < 4; k++)
                            if (wr_ben[k]) rd[8*k +: 8] = wr_data[8*k +: 8];
                end
            end
            if (wr_en && int'(wr_addr) < m_depth[i]) begin
                w = m_mem[i][wr_addr];
                for (int k = 0; k < 4; k++)
                    if (wr_ben[k]) w[8*k +: 8] = wr_data[8*k +: 8];
                m_mem[i][wr_addr] = w;
            end
        end else begin
            m_edges[i]++;
            if (m_edges[i] == m_depth[i])
                for (int a = 0; a < 32; a++) m_mem[i][a] = IV;
        end
        m_v[i][1] = m_v[i][0];
        m_d[i][1] = m_d[i][0];
        m_v[i][0] = rv;
        m_d[i][0] = rd;
        if (m_v[i][m_lat[i]-1]) m_last[i] = m_d[i][m_lat[i]-1];
    endtask

    task automatic model_check(input int i);
        check_val($sformatf("valid_%0d", i), 32'(rd_valid[i]), 32'(m_v[i][m_lat[i]-1]));
        check_val($sformatf("data_%0d", i), rd_data[i], m_last[i]);
        check_val($sformatf("init_done_%0d", i), 32'(init_done[i]), 32'(m_edges[i] >= m_depth[i]));
    endtask

    task automatic cycle();
        for (int i = 0; i < 3; i++) begin
            if (rst_n) model_edge(i);
            else       model_reset(i);
        end
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 3; i++) model_check(i);
    endtask

    task automatic drive(input bit we, input logic [3:0] ben, input logic [31:0] wd,
                         input logic [4:0] wa, input bit re, input logic [4:0] ra);
        wr_en   = we;
        wr_ben  = ben;
        wr_data = wd;
        wr_addr = wa;
        rd_en   = re;
        rd_addr = ra;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic rand_drive(input int amax);
        drive(1'($urandom), 4'($urandom), $urandom, 5'($urandom_range(0, amax)),
              1'($urandom), 5'($urandom_range(0, 31)));
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done[0] && n < 100) begin
            rand_drive(15);
            n++;
        end
        check_val(tag, 32'(n), 32'd32);
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            model_check(i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) model_reset(i);
        idle();
        idle();
        rst_n = 1'b1;

        // traffic during the sweep must be dropped; done after exactly DEPTH edges
        wait_init("init_latency");

        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd0);
        check_val("rd0_lat1", rd_data[1], IV);
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd31);
        check_val("rd31_lat1", rd_data[1], IV);
        check_val("rd0_lat2", rd_data[0], IV);
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd23);
        check_val("rd23_d24", rd_data[2], IV);
        idle();

        drive(1'b1, 4'hF, 32'h11223344, 5'd5, 1'b0, 5'd0);
        drive(1'b1, 4'b0101, 32'hAABBCCDD, 5'd5, 1'b0, 5'd0);
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd5);
        check_val("ben_lat1", rd_data[1], 32'h11BB33DD);
        idle();
        check_val("ben_lat2", rd_data[0], 32'h11BB33DD);

        drive(1'b1, 4'hF, 32'h0, 5'd7, 1'b0, 5'd0);
        drive(1'b1, 4'b1100, 32'hDEADBEEF, 5'd7, 1'b1, 5'd7);
        check_val("coll_v_lat1", 32'(rd_valid[1]), 32'd1);
        check_val("coll_d_lat1", rd_data[1], 32'hDEAD0000);
        check_val("coll_v_lat2_early", 32'(rd_valid[0]), 32'd0);
        idle();
        check_val("coll_v_lat2", 32'(rd_valid[0]), 32'd1);
        check_val("coll_d_lat2", rd_data[0], 32'hDEAD0000);
        idle();

        nv = 0;
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'(a));
            if (rd_valid[0]) nv++;
        end
        for (int a = 0; a < 3; a++) begin
            idle();
            if (rd_valid[0]) nv++;
        end
        check_val("burst_valid_count", 32'(nv), 32'd8);

        drive(1'b1, 4'hF, 32'hFFFFFFFF, 5'd30, 1'b0, 5'd0);
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd30);
        check_val("oor_valid", 32'(rd_valid[2]), 32'd1);
        check_val("oor_data", rd_data[2], 32'h0);
        check_val("inrange_d32", rd_data[1], 32'hFFFFFFFF);
        idle();

        for (int n = 0; n < 300; n++) rand_drive(31);

        drive(1'b1, 4'hF, 32'h5A5A1234, 5'd9, 1'b0, 5'd0);
        drive(1'b0, 4'h0, 32'h0, 5'd0, 1'b1, 5'd9);
        async_reset_check();
        idle();
        idle();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) rand_drive(31);
        async_reset_check();
        idle();
        rst_n = 1'b1;
        wait_init("init_latency_restart");
        for (int n = 0; n < 100; n++) rand_drive(31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
